// File: rtl/ram_rd_stream.sv
// Burst read streamer: issues sequential RAM reads under credit control and replays
// the returned words as a valid/ready stream. RAM_RD_STREAM_ABORT_EN adds cmd_abort.
module ram_rd_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int LEN_WIDTH  = 13,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_vld,
  output logic                  cmd_rdy,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
`ifdef RAM_RD_STREAM_ABORT_EN
  input  logic                  cmd_abort,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  ram_wr_en,
  output logic                  ram_addr_vld,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic                  ram_dout_vld,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  m_vld,
  input  logic                  m_rdy,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CRED = CW'(BUF_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e                state_q, state_d;
  logic                  cmd_rdy_q, cmd_rdy_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  addr_vld_q, addr_vld_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  addr_last_q, addr_last_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  rd_last_q, rd_last_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  iss_cnt_q, iss_cnt_d;
  logic [CW-1:0]         credit_q, credit_d;

  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [BUF_DEPTH];
  logic [BUF_DEPTH-1:0]  last_q, last_d;
  logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic abort, accept, issue, pop, push, wr_en, rd_en;

`ifdef RAM_RD_STREAM_ABORT_EN
  assign abort = cmd_abort & (state_q != IDLE);
`else
  assign abort = 1'b0;
`endif

  assign accept = cmd_vld & cmd_rdy_q & (state_q == IDLE);
  assign pop    = m_vld & m_rdy;
  // rd_pend_q marks the cycle a read's data is due; anything else is stray
  assign push   = ram_dout_vld & rd_pend_q;

  always_comb begin
    state_d     = state_q;
    cmd_rdy_d   = cmd_rdy_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    addr_d      = addr_q;
    addr_last_d = 1'b0;
    len_d       = len_q;
    iss_cnt_d   = iss_cnt_q;
    issue       = 1'b0;
    rd_pend_d   = addr_vld_q;
    rd_last_d   = addr_last_q;
    case (state_q)
      IDLE: begin
        cmd_rdy_d = 1'b1;
        if (accept) begin
          len_d = cmd_len;
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            issue       = 1'b1;
            addr_d      = cmd_addr;
            addr_last_d = (cmd_len == LEN_WIDTH'(1));
            iss_cnt_d   = LEN_WIDTH'(1);
            busy_d      = 1'b1;
            cmd_rdy_d   = 1'b0;
            state_d     = (cmd_len == LEN_WIDTH'(1)) ? DRAIN : ISSUE;
          end
        end
      end
      ISSUE: begin
        if (credit_q != '0) begin
          issue       = 1'b1;
          addr_d      = addr_q + ADDR_WIDTH'(1);
          addr_last_d = (iss_cnt_q == len_q - LEN_WIDTH'(1));
          iss_cnt_d   = iss_cnt_q + LEN_WIDTH'(1);
          if (addr_last_d) state_d = DRAIN;
        end
      end
      default: ;
    endcase
    if (abort) begin
      issue       = 1'b0;
      addr_d      = addr_q;
      addr_last_d = 1'b0;
      iss_cnt_d   = iss_cnt_q;
      rd_pend_d   = 1'b0;
      rd_last_d   = 1'b0;
      state_d     = DRAIN;
    end
    addr_vld_d = issue;
    credit_d   = abort ? FULL_CRED : credit_q - CW'(issue) + CW'(pop);
    // full credit in DRAIN means every issued word has left on the stream
    if ((state_q == DRAIN) && !abort && (credit_d == FULL_CRED)) begin
      done_d    = 1'b1;
      busy_d    = 1'b0;
      cmd_rdy_d = 1'b1;
      state_d   = IDLE;
    end
  end

  always_comb begin
    wr_en  = push & ~abort;
    rd_en  = pop & ~abort;
    mem_d  = mem_q;
    last_d = last_q;
    if (wr_en) begin
      mem_d[wptr_q]  = ram_dout;
      last_d[wptr_q] = rd_last_q;
    end
    wptr_d = wptr_q + PW'(wr_en);
    rptr_d = rptr_q + PW'(rd_en);
    cnt_d  = cnt_q + CW'(wr_en) - CW'(rd_en);
    if (abort) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_rdy_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      addr_vld_q  <= 1'b0;
      addr_q      <= '0;
      addr_last_q <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_last_q   <= 1'b0;
      len_q       <= '0;
      iss_cnt_q   <= '0;
      credit_q    <= FULL_CRED;
      mem_q       <= '{default: '0};
      last_q      <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_rdy_q   <= cmd_rdy_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      addr_vld_q  <= addr_vld_d;
      addr_q      <= addr_d;
      addr_last_q <= addr_last_d;
      rd_pend_q   <= rd_pend_d;
      rd_last_q   <= rd_last_d;
      len_q       <= len_d;
      iss_cnt_q   <= iss_cnt_d;
      credit_q    <= credit_d;
      mem_q       <= mem_d;
      last_q      <= last_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cmd_rdy      = cmd_rdy_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign ram_wr_en    = 1'b0;
  assign ram_addr_vld = addr_vld_q;
  assign ram_addr     = addr_q;
  assign m_vld        = (cnt_q != '0);
  assign m_data       = mem_q[rptr_q];
  assign m_last       = m_vld & last_q[rptr_q];

endmodule

// File: tb/tb_ram_rd_stream.sv
// Directed + randomized bench for ram_rd_stream against a queue-based model of the
// expected address sequence and data stream, fed by a behavioural 1-cycle RAM.
module tb_ram_rd_stream;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_vld, cmd_rdy;
  logic [11:0] cmd_addr;
  logic [12:0] cmd_len;
  logic        busy, done, ram_wr_en, ram_addr_vld;
  logic [11:0] ram_addr;
  logic        ram_dout_vld = 1'b0;
  logic [31:0] ram_dout = '0;
  logic        m_vld, m_rdy, m_last;
  logic [31:0] m_data;
  logic        spur;
`ifdef RAM_RD_STREAM_ABORT_EN
  logic        cmd_abort;
`endif

  ram_rd_stream dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
`ifdef RAM_RD_STREAM_ABORT_EN
    .cmd_abort(cmd_abort),
`endif
    .busy(busy), .done(done), .ram_wr_en(ram_wr_en),
    .ram_addr_vld(ram_addr_vld), .ram_addr(ram_addr),
    .ram_dout_vld(ram_dout_vld), .ram_dout(ram_dout),
    .m_vld(m_vld), .m_rdy(m_rdy), .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [4096];

  // behavioural RAM: data one cycle after the strobe; spur injects a stray data-valid
  always @(posedge clk) begin
    ram_dout_vld <= ram_addr_vld | spur;
    ram_dout     <= ram_addr_vld ? mem[ram_addr] : 32'($urandom);
  end

  int          checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  int          cyc = 0, iss_tot = 0, pop_tot = 0, beats = 0, done_cnt = 0, done_cyc = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] held = '0;
  logic [11:0] exp_addr [$];
  logic [32:0] exp_data [$];

  task automatic step(input logic rdy);
    logic [11:0] ea;
    logic [32:0] ed;
    @(posedge clk); #1;
    m_rdy = rdy;
    cyc++;
    if (ram_addr_vld) begin
      chk("addr_expected", exp_addr.size() > 0, 1'b1);
      if (exp_addr.size() > 0) begin
        ea = exp_addr.pop_front();
        chk("ram_addr", ram_addr, ea);
      end
      iss_tot++;
    end
    chk("outstanding", (iss_tot - pop_tot) <= 4, 1'b1);
    if (stall_prev) begin
      chk("stall_vld", m_vld, 1'b1);
      chk("stall_data", m_data, held);
    end
    if (m_vld) chk("vld_expected", exp_data.size() > 0, 1'b1);
    if (m_vld && m_rdy && exp_data.size() > 0) begin
      ed = exp_data.pop_front();
      chk("beat", {m_last, m_data}, ed);
      pop_tot++;
      beats++;
    end
    stall_prev = m_vld & ~m_rdy;
    held = m_data;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("done_busy", busy, 1'b0);
      chk("done_cmd_rdy", cmd_rdy, 1'b1);
    end
  endtask

  task automatic check_reset();
    chk("rst_cmd_rdy", cmd_rdy, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_addr_vld", ram_addr_vld, 1'b0);
    chk("rst_addr", ram_addr, 12'h000);
    chk("rst_m_vld", m_vld, 1'b0);
    chk("rst_m_last", m_last, 1'b0);
    chk("rst_m_data", m_data, 32'h0);
  endtask

  task automatic expect_burst(input logic [11:0] a, input logic [12:0] l);
    logic [11:0] ad;
    exp_addr.delete();
    exp_data.delete();
    iss_tot = 0; pop_tot = 0; beats = 0; done_cnt = 0;
    for (int i = 0; i < int'(l); i++) begin
      ad = a + 12'(i);
      exp_addr.push_back(ad);
      exp_data.push_back({(i == int'(l) - 1), mem[ad]});
    end
  endtask

  // Called in the cycle the command is to be accepted; returns after done + 1 cycle.
  task automatic burst(input logic [11:0] a, input logic [12:0] l, input int sb, input int sl,
                       input bit rnd, input bit timed);
    int   acc, r;
    logic rdy;
    chk("cmd_rdy_idle", cmd_rdy, 1'b1);
    expect_burst(a, l);
    cmd_vld = 1'b1; cmd_addr = a; cmd_len = l; acc = cyc;
    for (int k = 0; k < 400 && done_cnt == 0; k++) begin
      r   = cyc + 1 - acc;
      rdy = rnd ? ($urandom_range(0, 3) != 0) : !(r >= sb && r < sb + sl);
      step(rdy);
      if (k == 0) begin
        cmd_vld = 1'b0; cmd_addr = 12'($urandom); cmd_len = 13'($urandom);
        chk("busy_rise", busy, (l != 0));
      end
    end
    chk("done_seen", done_cnt, 1);
    if (timed) chk("done_cycle", done_cyc - acc, (l == 0) ? 1 : int'(l) + 3);
    chk("beat_count", beats, int'(l));
    chk("addr_left", exp_addr.size(), 0);
    chk("data_left", exp_data.size(), 0);
    step(1'b1);
    chk("done_pulse", done, 1'b0);
  endtask

  initial begin
    logic [11:0] a;
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    rst_n = 1'b0; cmd_vld = 1'b0; cmd_addr = '0; cmd_len = '0; m_rdy = 1'b0; spur = 1'b0;
`ifdef RAM_RD_STREAM_ABORT_EN
    cmd_abort = 1'b0;
`endif
    #2;
    check_reset();
    step(1'b1); step(1'b1);
    rst_n = 1'b1;
    step(1'b1);
    chk("cmd_rdy_release", cmd_rdy, 1'b1);
    chk("ram_wr_en", ram_wr_en, 1'b0);

    burst(12'h010, 13'd8, 0, 0, 1'b0, 1'b1);
    burst(12'hFFE, 13'd4, 0, 0, 1'b0, 1'b1);
    burst(12'($urandom), 13'd20, 6, 10, 1'b0, 1'b0);
    burst(12'($urandom), 13'd0, 0, 0, 1'b0, 1'b1);

    // reset mid-burst, then a stray data-valid after release
    a = 12'($urandom);
    expect_burst(a, 13'd20);
    cmd_vld = 1'b1; cmd_addr = a; cmd_len = 13'd20;
    step(1'b1);
    cmd_vld = 1'b0;
    repeat (5) step(1'b1);
    rst_n = 1'b0;
    #1;
    check_reset();
    exp_addr.delete(); exp_data.delete(); stall_prev = 1'b0;
    step(1'b1); step(1'b1);
    rst_n = 1'b1; spur = 1'b1;
    step(1'b1);
    spur = 1'b0;
    chk("cmd_rdy_after_rst", cmd_rdy, 1'b1);
    step(1'b1); step(1'b1);
    chk("stray_ignored", m_vld, 1'b0);
    burst(12'($urandom), 13'd2, 0, 0, 1'b0, 1'b1);

    for (int t = 0; t < 8; t++)
      burst(12'($urandom_range(4080, 4095)) + 12'(t * 517), 13'($urandom_range(1, 12)), 0, 0, 1'b1, 1'b0);

`ifdef RAM_RD_STREAM_ABORT_EN
    a = 12'($urandom);
    expect_burst(a, 13'd16);
    cmd_vld = 1'b1; cmd_addr = a; cmd_len = 13'd16;
    step(1'b1);
    cmd_vld = 1'b0;
    for (int k = 0; k < 50 && beats < 3; k++) step(1'b1);
    step(1'b0);
    cmd_abort = 1'b1;
    stall_prev = 1'b0; exp_addr.delete(); exp_data.delete(); done_cnt = 0;
    step(1'b1);
    cmd_abort = 1'b0;
    chk("abort_vld_drop", m_vld, 1'b0);
    if (done_cnt == 0) step(1'b1);
    chk("abort_done", done_cnt, 1);
    step(1'b1);
    burst(12'($urandom), 13'd1, 0, 0, 1'b0, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram_rd_stream.md
# ram_rd_stream

Read-side streaming front end for the valid-qualified dual-port RAM wrapper. It accepts a burst command (start address, length) and issues sequential read addresses with an address-valid strobe on one RAM port. It captures the data returned one cycle later, flagged by the RAM's data-valid, into a small credit-protected buffer. The data leaves as a valid/ready stream with a last flag, ready for a downstream packetiser or DMA.

## Interface
Parameters:
- DATA_WIDTH, 32, RAM word width
- ADDR_WIDTH, 12, RAM address width
- LEN_WIDTH, 13, burst length field width (max burst 2^LEN_WIDTH-1 words)
- BUF_DEPTH, 4, output buffer entries; power of two, ≥2

Ports:
- clk  in  1  sole clock; also drives the RAM port in use
- rst_n  in  1  asynchronous active-low reset
- cmd_vld  in  1  command valid
- cmd_rdy  out  1  command accepted when cmd_vld & cmd_rdy
- cmd_addr  in  ADDR_WIDTH  first word address
- cmd_len  in  LEN_WIDTH  word count
- busy  out  1  high from command accept until done
- done  out  1  one-cycle pulse at burst completion
- ram_wr_en  out  1  constant 0
- ram_addr_vld  out  1  read strobe to RAM
- ram_addr  out  ADDR_WIDTH  read address
- ram_dout_vld  in  1  RAM read data valid, one cycle after ram_addr_vld
- ram_dout  in  DATA_WIDTH  RAM read data
- m_vld  out  1  stream valid
- m_rdy  in  1  stream ready
- m_data  out  DATA_WIDTH  stream data
- m_last  out  1  marks the final word of the burst

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE: cmd_rdy=1. On accept, latch the address and length.
  - len=0: stay in IDLE and pulse done next cycle. No RAM access and no stream beat.
  - len>0: go to ISSUE.
- ISSUE: issue one read per cycle while credit>0.
  - Credit = BUF_DEPTH − buffer occupancy − reads in flight. Decrement on issue, increment on stream pop. The buffer can never overflow.
  - Address increments by 1 and wraps modulo 2^ADDR_WIDTH (4095→0 at default).
  - After the last issue, go to DRAIN.
- DRAIN: wait until every issued word has been popped on the stream. Then pulse done and go to IDLE.
- Capture: every cycle with ram_dout_vld=1, ram_dout is pushed into the buffer (in-order FIFO).
- m_last=1 on the beat whose index equals len−1. It is tagged using an issue-side counter that travels with the read.
- m_data is held stable while m_vld & !m_rdy.
- ram_dout_vld while no read is in flight: the word is ignored and must not enter the buffer.
- Simultaneous push and pop with the buffer full or empty: occupancy is unchanged and data order is preserved.

## Timing
- Reset values: cmd_rdy=0 during reset and 1 in the first cycle after release. All other outputs are 0: busy, done, ram_addr_vld, ram_addr, m_vld, m_last, m_data.
- ram_addr_vld and ram_addr are registered.
- Command accepted in cycle N → first ram_addr_vld in N+1 → ram_dout_vld in N+2 → m_vld in N+3.
- With m_rdy held high, throughput is 1 word/cycle. Last beat arrives at N+2+len, done at N+3+len.
- busy rises in N+1 and falls in the done cycle. cmd_rdy returns high in the cycle done is asserted.
- Reset asserted mid-burst: all state is cleared immediately. Buffer contents and in-flight reads are dropped, and a late ram_dout_vld after release is ignored.

## Configuration
- RAM_RD_STREAM_ABORT_EN defined: adds an input port cmd_abort (1 bit).
  - cmd_abort high in ISSUE or DRAIN stops issuing, flushes the buffer and discards in-flight data.
  - The FSM enters DRAIN until no read is in flight, then pulses done. m_vld drops the cycle after abort.
  - cmd_abort in IDLE has no effect.
- Not defined: the port is absent and bursts always run to completion.

## Test plan
- Reset, then cmd addr=0x010, len=8, m_rdy=1 → ram_addr 0x010..0x017 on consecutive cycles; 8 beats with data matching preloaded RAM; m_last on beat 8; done 11 cycles after accept.
- cmd addr=0xFFE, len=4 → addresses 0xFFE, 0xFFF, 0x000, 0x001; data in the same order.
- len=20, m_rdy low for 10 cycles mid-burst → at most BUF_DEPTH (4) reads outstanding plus buffered; no data lost or duplicated; m_data stable while stalled.
- len=0 → done pulse one cycle after accept; ram_addr_vld and m_vld never asserted.
- rst_n pulsed low mid-burst, then len=2 → outputs are at reset values; the new burst delivers exactly 2 correct beats.
- With RAM_RD_STREAM_ABORT_EN: len=16, abort after beat 3 → m_vld low the next cycle; done within 2 cycles; the following len=1 cmd returns the correct word.
